uart_parity_engine: RTL and testbench

//  Serial, frame-level parity generator/checker for the UART full-duplex datapath.
//  - Accumulates parity one data bit at a time, as the TX shifter sends bits or the RX sampler receives them.
//  - TX (check_en=0): supplies the parity bit for the frame's parity slot.
//  - RX (check_en=1): compares the received parity bit with the expected one, flags an error
//    and keeps a saturating error count.
//  - Data length and parity mode are set at run time, per frame.

---
 rtl/uart_parity_pkg.sv | 39 +++
 rtl/sat_err_counter.sv | 25 ++
 rtl/uart_parity_engine.sv | 144 ++++++++++++++
 tb/tb_uart_parity_engine.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_parity_pkg.sv
// Shared definitions for the UART parity engine and the TX/RX frame controllers:
// parity-type codes, FSM state encoding and parity helper functions.
package uart_parity_pkg;

    localparam logic [2:0] PAR_NONE  = 3'b000;
    localparam logic [2:0] PAR_ODD   = 3'b001;
    localparam logic [2:0] PAR_EVEN  = 3'b010;
    localparam logic [2:0] PAR_MARK  = 3'b011;
    localparam logic [2:0] PAR_SPACE = 3'b100;

    localparam int MIN_DATA_LEN = 5;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCUM  = 2'd1,
        ST_PARITY = 2'd2,
        ST_FIN    = 2'd3
    } par_state_e;

    // Codes 101..111 are treated exactly like PAR_NONE.
    function automatic logic has_parity_slot(input logic [2:0] ptype);
        return (ptype == PAR_ODD) || (ptype == PAR_EVEN) ||
               (ptype == PAR_MARK) || (ptype == PAR_SPACE);
    endfunction

    function automatic logic parity_for(input logic [2:0] ptype, input logic acc);
        logic p;
        p = 1'b1;
        case (ptype)
            PAR_ODD:   p = ~acc;
            PAR_EVEN:  p = acc;
            PAR_MARK:  p = 1'b1;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b1;
        endcase
        return p;
    endfunction

endpackage

// File: rtl/sat_err_counter.sv
// Saturating event counter: counts inc pulses, holds at all-ones, clr wins
// but still counts an inc arriving in the same cycle.
module sat_err_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] count
);

    // NOTE: reset is sampled on the clock edge only, so it sits inside the
    // clocked branch and is not in the sensitivity list.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? CNT_W'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/uart_parity_engine.sv
// Frame-level serial parity generator (TX) / checker (RX) with a saturating
// parity-error counter. One data bit is folded into the accumulator per bit_valid.
module uart_parity_engine
    import uart_parity_pkg::*;
#(
    parameter int DATA_W_MAX = 9,
    parameter int CNT_W      = 8,
    localparam int LEN_W     = $clog2(DATA_W_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             check_en,
    input  logic [2:0]       parity_type,
    input  logic [LEN_W-1:0] data_len,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic             err_clr,
    output logic             parity_bit,
    output logic             par_valid,
    output logic             busy,
    output logic             done,
    output logic             parity_err,
    output logic [CNT_W-1:0] err_count
);

    par_state_e       state_q, state_d;
    logic             acc_q, acc_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [2:0]       ptype_q, ptype_d;
    logic             chk_q, chk_d;
    logic             mis_q, mis_d;
    logic             pbit_q, pbit_d;
    logic [LEN_W-1:0] len_clamped;

    always_comb begin
        len_clamped = data_len;
        if (data_len < LEN_W'(MIN_DATA_LEN)) begin
            len_clamped = LEN_W'(MIN_DATA_LEN);
        end else if (data_len > LEN_W'(DATA_W_MAX)) begin
            len_clamped = LEN_W'(DATA_W_MAX);
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        ptype_d = ptype_q;
        chk_d   = chk_q;
        mis_d   = mis_q;
        pbit_d  = 1'b1;

        if (start) begin
            // A start anywhere aborts the current frame; a coincident bit is dropped.
            state_d = ST_ACCUM;
            acc_d   = 1'b0;
            cnt_d   = '0;
            len_d   = len_clamped;
            ptype_d = parity_type;
            chk_d   = check_en;
            mis_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mis_d = 1'b0;
                end
                ST_ACCUM: begin
                    if (bit_valid) begin
                        acc_d = acc_q ^ bit_in;
                        cnt_d = cnt_q + LEN_W'(1);
                        if (cnt_d == len_q) begin
                            if (has_parity_slot(ptype_q)) begin
                                state_d = ST_PARITY;
                                pbit_d  = parity_for(ptype_q, acc_d);
                            end else begin
                                state_d = ST_FIN;
                                mis_d   = 1'b0;
                            end
                        end
                    end
                end
                ST_PARITY: begin
                    pbit_d = pbit_q;
                    if (bit_valid) begin
                        state_d = ST_FIN;
                        pbit_d  = 1'b1;
                        mis_d   = chk_q && (bit_in != pbit_q);
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                    mis_d   = 1'b0;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge values computed above.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            acc_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= LEN_W'(MIN_DATA_LEN);
            ptype_q <= PAR_NONE;
            chk_q   <= 1'b0;
            mis_q   <= 1'b0;
            pbit_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            ptype_q <= ptype_d;
            chk_q   <= chk_d;
            mis_q   <= mis_d;
            pbit_q  <= pbit_d;
        end
    end

    assign parity_bit = pbit_q;
    assign par_valid  = (state_q == ST_PARITY);
    assign busy       = (state_q == ST_ACCUM) || (state_q == ST_PARITY);
    assign done       = (state_q == ST_FIN);
    assign parity_err = done && mis_q;

    sat_err_counter #(
        .CNT_W (CNT_W)
    ) u_err_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .inc     (parity_err),
        .clr     (err_clr),
        .count   (err_count)
    );

endmodule

// File: tb/tb_uart_parity_engine.sv
// Self-checking bench for uart_parity_engine: hand-computed vector table,
// multi-cycle corner sequences and randomized frames against a frame-level model.
module tb_uart_parity_engine;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       start;
    logic       check_en;
    logic [2:0] parity_type;
    logic [3:0] data_len;
    logic       bit_valid;
    logic       bit_in;
    logic       err_clr;

    logic       parity_bit, par_valid, busy, done, parity_err;
    logic [7:0] err_count;
    logic       s_parity_bit, s_par_valid, s_busy, s_done, s_parity_err;
    logic [1:0] s_err_count;

    int checks   = 0;
    int failures = 0;
    int cnt8     = 0;
    int cnt2     = 0;

    always #5 clk = ~clk;

    uart_parity_engine dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .check_en    (check_en),
        .parity_type (parity_type),
        .data_len    (data_len),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .err_clr     (err_clr),
        .parity_bit  (parity_bit),
        .par_valid   (par_valid),
        .busy        (busy),
        .done        (done),
        .parity_err  (parity_err),
        .err_count   (err_count)
    );

    // Second instance with a 2-bit counter sees identical stimulus; only its count is checked.
    uart_parity_engine #(.CNT_W(2)) dut_sat (
        .clk         (clk),
        .reset_n     (reset_n),
        .start       (start),
        .check_en    (check_en),
        .parity_type (parity_type),
        .data_len    (data_len),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .err_clr     (err_clr),
        .parity_bit  (s_parity_bit),
        .par_valid   (s_par_valid),
        .busy        (s_busy),
        .done        (s_done),
        .parity_err  (s_parity_err),
        .err_count   (s_err_count)
    );

    typedef struct {
        logic [2:0] ptype;
        logic       chk;
        logic [3:0] dlen;
        logic [8:0] data;     // data[0] is sent first
        logic       rx_par;
        int         exp_len;
        bit         exp_has_par;
        logic       exp_par;
        logic       exp_err;
    } vec_t;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic scramble_cfg();
        check_en    = 1'($urandom);
        parity_type = 3'($urandom_range(7, 0));
        data_len    = 4'($urandom_range(15, 0));
    endtask

    function automatic vec_t mk(input logic [2:0] pt, input logic chk, input logic [3:0] dl,
                                input logic [8:0] data, input logic rxp, input int len,
                                input bit has_par, input logic par, input logic err);
        vec_t v;
        v.ptype = pt; v.chk = chk; v.dlen = dl; v.data = data; v.rx_par = rxp;
        v.exp_len = len; v.exp_has_par = has_par; v.exp_par = par; v.exp_err = err;
        return v;
    endfunction

    // Frame-level reference: parity chosen so the total count of ones is odd/even.
    function automatic vec_t model(input logic [2:0] pt, input logic chk, input logic [3:0] dl,
                                   input logic [8:0] data, input logic rxp);
        vec_t v;
        int   ones;
        ones = 0;
        v.ptype = pt; v.chk = chk; v.dlen = dl; v.data = data; v.rx_par = rxp;
        v.exp_len = (int'(dl) < 5) ? 5 : ((int'(dl) > 9) ? 9 : int'(dl));
        for (int i = 0; i < v.exp_len; i++) ones += int'(data[i]);
        v.exp_has_par = 1'b1;
        case (pt)
            3'd1:    v.exp_par = (ones % 2 == 0);
            3'd2:    v.exp_par = (ones % 2 == 1);
            3'd3:    v.exp_par = 1'b1;
            3'd4:    v.exp_par = 1'b0;
            default: begin v.exp_has_par = 1'b0; v.exp_par = 1'b1; end
        endcase
        v.exp_err = chk && v.exp_has_par && (rxp != v.exp_par);
        return v;
    endfunction

    task automatic run_frame(input vec_t v, input bit bv_at_start, input bit clr_in_fin,
                             input int gap_max, input string tag);
        int gaps;
        start       = 1'b1;
        check_en    = v.chk;
        parity_type = v.ptype;
        data_len    = v.dlen;
        bit_valid   = bv_at_start;
        bit_in      = 1'b1;
        step();
        start     = 1'b0;
        bit_valid = 1'b0;
        scramble_cfg();
        check({tag, ":start_busy"}, busy, 1);
        check({tag, ":start_done"}, done, 0);
        check({tag, ":start_pv"}, par_valid, 0);
        for (int i = 0; i < v.exp_len; i++) begin
            gaps = $urandom_range(gap_max, 0);
            repeat (gaps) begin
                bit_in = 1'($urandom);
                step();
            end
            bit_valid = 1'b1;
            bit_in    = v.data[i];
            step();
            bit_valid = 1'b0;
            if (i < v.exp_len - 1) begin
                check({tag, ":acc_busy"}, busy, 1);
                check({tag, ":acc_done"}, done, 0);
                check({tag, ":acc_pbit"}, parity_bit, 1);
            end
        end
        if (v.exp_has_par) begin
            check({tag, ":par_valid"}, par_valid, 1);
            check({tag, ":par_bit"}, parity_bit, v.exp_par);
            check({tag, ":par_done"}, done, 0);
            gaps = $urandom_range(gap_max, 0);
            repeat (gaps) begin
                bit_in = 1'($urandom);
                step();
                check({tag, ":par_hold"}, {par_valid, parity_bit}, {1'b1, v.exp_par});
            end
            bit_valid = 1'b1;
            bit_in    = v.rx_par;
            step();
            bit_valid = 1'b0;
        end
        check({tag, ":fin_done"}, done, 1);
        check({tag, ":fin_err"}, parity_err, v.exp_err);
        check({tag, ":fin_pv_busy"}, {par_valid, busy}, 0);
        check({tag, ":fin_pbit"}, parity_bit, 1);
        check({tag, ":fin_cnt"}, err_count, cnt8);
        err_clr = clr_in_fin;
        step();
        err_clr = 1'b0;
        if (clr_in_fin) begin
            cnt8 = v.exp_err ? 1 : 0;
            cnt2 = v.exp_err ? 1 : 0;
        end else if (v.exp_err) begin
            if (cnt8 < 255) cnt8++;
            if (cnt2 < 3) cnt2++;
        end
        check({tag, ":post_done"}, {done, parity_err, busy}, 0);
        check({tag, ":post_cnt"}, err_count, cnt8);
        check({tag, ":post_cnt_sat"}, s_err_count, cnt2);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ":pbit"}, parity_bit, 1);
        check({tag, ":flags"}, {par_valid, busy, done, parity_err}, 0);
        check({tag, ":cnt"}, err_count, 0);
        check({tag, ":cnt_sat"}, s_err_count, 0);
    endtask

    vec_t table_v[13];

    initial begin
        // Even, 8 bits 1,0,1,1,0,0,0,0 -> three ones -> parity 1
        table_v[0]  = mk(3'b010, 1'b0, 4'd8,  9'h00D, 1'b0, 8, 1, 1'b1, 1'b0);
        // Odd, 7 bits 1101001 -> four ones -> expected 1, received 1
        table_v[1]  = mk(3'b001, 1'b1, 4'd7,  9'h04B, 1'b1, 7, 1, 1'b1, 1'b0);
        // Even, 0xFF -> expected 0, received 1 -> error
        table_v[2]  = mk(3'b010, 1'b1, 4'd8,  9'h0FF, 1'b1, 8, 1, 1'b0, 1'b1);
        table_v[3]  = mk(3'b000, 1'b0, 4'd5,  9'h015, 1'b0, 5, 0, 1'b1, 1'b0);
        table_v[4]  = mk(3'b011, 1'b0, 4'd5,  9'h000, 1'b0, 5, 1, 1'b1, 1'b0);
        table_v[5]  = mk(3'b100, 1'b0, 4'd5,  9'h01F, 1'b0, 5, 1, 1'b0, 1'b0);
        // data_len 3 clamps to 5: ones in first five bits = 3
        table_v[6]  = mk(3'b010, 1'b0, 4'd3,  9'h007, 1'b0, 5, 1, 1'b1, 1'b0);
        // data_len 12 clamps to 9: nine ones -> odd parity 0
        table_v[7]  = mk(3'b001, 1'b1, 4'd12, 9'h1FF, 1'b0, 9, 1, 1'b0, 1'b0);
        // only the ninth bit set -> odd parity 0, received 1 -> error
        table_v[8]  = mk(3'b001, 1'b1, 4'd9,  9'h100, 1'b1, 9, 1, 1'b0, 1'b1);
        table_v[9]  = mk(3'b111, 1'b1, 4'd6,  9'h03F, 1'b1, 6, 0, 1'b1, 1'b0);
        table_v[10] = mk(3'b100, 1'b1, 4'd5,  9'h000, 1'b1, 5, 1, 1'b0, 1'b1);
        table_v[11] = mk(3'b011, 1'b1, 4'd6,  9'h000, 1'b1, 6, 1, 1'b1, 1'b0);
        table_v[12] = mk(3'b010, 1'b1, 4'd0,  9'h1E0, 1'b0, 5, 1, 1'b0, 1'b0);

        reset_n = 1'b0; start = 1'b0; check_en = 1'b0; parity_type = 3'b000;
        data_len = 4'd8; bit_valid = 1'b0; bit_in = 1'b0; err_clr = 1'b0;
        #1;
        step();
        step();
        check_reset_outputs("reset");
        reset_n = 1'b1;
        bit_valid = 1'b1; bit_in = 1'b1;
        step();
        bit_valid = 1'b0;
        check("idle_ignores_bv", {busy, done, par_valid}, 0);

        for (int k = 0; k < 13; k++)
            run_frame(table_v[k], 1'b0, 1'b0, 1, $sformatf("vec%0d", k));

        // Restart from ACCUM after 3 of 8 bits, then a full even frame of 0x01.
        start = 1'b1; check_en = 1'b0; parity_type = 3'b010; data_len = 4'd8;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            bit_valid = 1'b1; bit_in = 1'b1;
            step();
            check("abort_acc_done", done, 0);
        end
        bit_valid = 1'b0;
        run_frame(model(3'b010, 1'b0, 4'd8, 9'h001, 1'b0), 1'b0, 1'b0, 0, "restart_acc");

        // Restart from PARITY with a coincident bit_valid: the bit is dropped.
        start = 1'b1; check_en = 1'b1; parity_type = 3'b001; data_len = 4'd5;
        step();
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b0;
        repeat (5) step();
        bit_valid = 1'b0;
        check("abort_par_pv", par_valid, 1);
        run_frame(model(3'b100, 1'b1, 4'd5, 9'h000, 1'b0), 1'b1, 1'b0, 0, "restart_par");

        // Reset in the middle of a frame.
        start = 1'b1; check_en = 1'b1; parity_type = 3'b001; data_len = 4'd8;
        step();
        start = 1'b0; bit_valid = 1'b1; bit_in = 1'b1;
        repeat (4) step();
        bit_valid = 1'b0;
        reset_n = 1'b0;
        step();
        cnt8 = 0; cnt2 = 0;
        check_reset_outputs("mid_reset");
        reset_n = 1'b1;
        step();
        check("mid_reset_no_done", {done, busy}, 0);

        // Saturation of the 2-bit counter, then err_clr alone and with an error.
        for (int k = 0; k < 4; k++)
            run_frame(model(3'b100, 1'b1, 4'd5, 9'h000, 1'b1), 1'b0, 1'b0, 0, "sat");
        check("sat_cnt2", s_err_count, 3);
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        cnt8 = 0; cnt2 = 0;
        check("clr_idle", err_count, 0);
        run_frame(model(3'b100, 1'b1, 4'd5, 9'h000, 1'b1), 1'b0, 1'b0, 0, "clr_pre");
        run_frame(model(3'b100, 1'b1, 4'd5, 9'h000, 1'b1), 1'b0, 1'b1, 0, "clr_err");
        check("clr_err_cnt", err_count, 1);

        // Randomized frames against the model.
        for (int k = 0; k < 200; k++) begin
            vec_t v;
            v = model(3'($urandom_range(7, 0)), 1'($urandom), 4'($urandom_range(15, 0)),
                      9'($urandom), 1'($urandom));
            run_frame(v, 1'b0, ($urandom_range(15, 0) == 0), 2, $sformatf("rnd%0d", k));
        end

        // Drive the 8-bit counter into saturation.
        for (int k = 0; k < 260; k++)
            run_frame(model(3'b100, 1'b1, 4'd5, 9'h000, 1'b1), 1'b0, 1'b0, 0, "sat8");
        check("sat8_cnt", err_count, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
